// File: rtl/fifo_stream_reader_if.sv
//------------------------------------------------------------------------------
// Module   : fifo_stream_reader_if
// Purpose  : FIFO read side plus valid/ready output stream for fifo_stream_reader.
//            FIFO_STREAM_READER_CNT_EN adds word_count/count_clear.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface fifo_stream_reader_if #(
    parameter int WIDTH = 8
);
    logic             run;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_data;
    logic             read_enable;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
`ifdef FIFO_STREAM_READER_CNT_EN
    logic [31:0]      word_count;
    logic             count_clear;

    modport master (
        input  run, fifo_empty, fifo_data, out_ready, count_clear,
        output read_enable, out_data, out_valid, busy, word_count
    );
    modport slave (
        output run, fifo_empty, fifo_data, out_ready, count_clear,
        input  read_enable, out_data, out_valid, busy, word_count
    );
`else
    modport master (
        input  run, fifo_empty, fifo_data, out_ready,
        output read_enable, out_data, out_valid, busy
    );
    modport slave (
        output run, fifo_empty, fifo_data, out_ready,
        input  read_enable, out_data, out_valid, busy
    );
`endif
endinterface

`default_nettype wire

// File: rtl/fifo_stream_reader.sv
//------------------------------------------------------------------------------
// Module   : fifo_stream_reader
// Purpose  : Pops a 1-cycle-latency FIFO into a 2-entry valid/ready output buffer.
//            Optional pop counter enabled by FIFO_STREAM_READER_CNT_EN.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module fifo_stream_reader #(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    fifo_stream_reader_if.master  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t           r_state;
    logic [1:0]       r_occ;
    logic             r_inflight;
    logic [WIDTH-1:0] r_buf0;
    logic [WIDTH-1:0] r_buf1;

    logic             w_pop;
    logic [2:0]       w_level;
    logic             w_read_enable;

    assign w_pop   = (r_occ != 2'd0) && bus.out_ready;
    assign w_level = {1'b0, r_occ} + {2'b00, r_inflight};

    // Words already owned (buffered + in flight) minus this cycle's pop must leave room.
    assign w_read_enable = !reset && (r_state == S_RUN) && !bus.fifo_empty
                           && (w_level < (3'd2 + {2'b00, w_pop}));

    assign bus.read_enable = w_read_enable;
    assign bus.out_valid   = (r_occ != 2'd0);
    assign bus.out_data    = r_buf0;
    assign bus.busy        = (r_state != S_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_occ      <= 2'd0;
            r_inflight <= 1'b0;
            r_buf0     <= '0;
            r_buf1     <= '0;
        end else begin
            r_inflight <= w_read_enable;

            case (r_state)
                S_IDLE:  if (bus.run) r_state <= S_RUN;
                S_RUN:   if (!bus.run) r_state <= S_DRAIN;
                S_DRAIN: begin
                    if (bus.run)
                        r_state <= S_RUN;
                    else if ((r_occ == 2'd0) && !r_inflight)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase

            // Capture and pop in the same cycle keep occupancy constant.
            if (w_pop) begin
                if (r_inflight) begin
                    if (r_occ == 2'd2) begin
                        r_buf0 <= r_buf1;
                        r_buf1 <= bus.fifo_data;
                    end else begin
                        r_buf0 <= bus.fifo_data;
                    end
                end else begin
                    r_buf0 <= r_buf1;
                    r_occ  <= r_occ - 2'd1;
                end
            end else if (r_inflight) begin
                if (r_occ == 2'd0)
                    r_buf0 <= bus.fifo_data;
                else
                    r_buf1 <= bus.fifo_data;
                r_occ <= r_occ + 2'd1;
            end
        end
    end

    a_occ_range: assert property (@(posedge clk) disable iff (reset) r_occ <= 2'd2);

`ifdef FIFO_STREAM_READER_CNT_EN
    logic [31:0] r_word_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_word_count <= 32'd0;
        else if (bus.count_clear)
            r_word_count <= 32'd0;
        else if (w_pop)
            r_word_count <= r_word_count + 32'd1;
    end

    assign bus.word_count = r_word_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_stream_reader.sv
//------------------------------------------------------------------------------
// Module   : tb_fifo_stream_reader
// Purpose  : Self-checking bench for fifo_stream_reader against a queue-based model.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_fifo_stream_reader;
    localparam int WIDTH   = 8;
    localparam int c_IDLE  = 0;
    localparam int c_RUN   = 1;
    localparam int c_DRAIN = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    fifo_stream_reader_if #(.WIDTH(WIDTH)) bus ();
    fifo_stream_reader #(.WIDTH(WIDTH)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] q_fifo[$];
    logic [7:0] m_buf[$];
    logic [7:0] exp_seq[$];
    logic [7:0] deliv[$];
    bit         m_infl;
    logic [7:0] m_infl_word;
    int         m_mode;
    bit         force_empty;
    bit         toggle_empty;
    int         cyc, base, re_count, first_re, first_valid;
`ifdef FIFO_STREAM_READER_CNT_EN
    logic [31:0] m_count;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_model();
        m_buf.delete();
        m_infl = 1'b0;
        m_mode = c_IDLE;
`ifdef FIFO_STREAM_READER_CNT_EN
        m_count = 32'd0;
`endif
    endtask

    task automatic clear_obs();
        re_count    = 0;
        first_re    = -1;
        first_valid = -1;
        deliv.delete();
        base        = cyc;
    endtask

    task automatic drive_fifo();
        bus.fifo_empty = (q_fifo.size() == 0) || force_empty;
    endtask

    // One clock: compare at negedge, advance the model at posedge, drive FIFO outputs after.
    task automatic tick();
        bit         e_re, e_valid, e_busy, e_pop;
        int         nb;
        bit         inf;
        @(negedge clk);
        e_re = 0; e_valid = 0; e_busy = 0; e_pop = 0;
        if (reset) begin
            check("rst_out_data", bus.out_data, 0);
        end else begin
            e_valid = (m_buf.size() > 0);
            e_pop   = e_valid && bus.out_ready;
            e_re    = (m_mode == c_RUN) && !bus.fifo_empty
                      && (m_buf.size() + int'(m_infl) < 2 + int'(e_pop));
            e_busy  = (m_mode != c_IDLE);
            if (e_valid) check("out_data", bus.out_data, m_buf[0]);
        end
        check("read_enable", bus.read_enable, e_re);
        check("out_valid", bus.out_valid, e_valid);
        check("busy", bus.busy, e_busy);
        if (bus.fifo_empty) check("re_while_empty", bus.read_enable, 0);
`ifdef FIFO_STREAM_READER_CNT_EN
        check("word_count", bus.word_count, m_count);
`endif
        if (!reset) begin
            if (bus.read_enable) begin
                re_count++;
                if (first_re < 0) first_re = cyc - base;
            end
            if (bus.out_valid && first_valid < 0) first_valid = cyc - base;
            if (bus.out_valid && bus.out_ready) deliv.push_back(bus.out_data);
        end
        @(posedge clk);
        cyc++;
        if (reset) begin
            clear_model();
        end else begin
            nb  = m_buf.size();
            inf = m_infl;
            if (e_pop) void'(m_buf.pop_front());
            if (m_infl) m_buf.push_back(m_infl_word);
            m_infl = e_re;
            if (e_re && q_fifo.size() > 0) m_infl_word = q_fifo.pop_front();
            case (m_mode)
                c_IDLE:  if (bus.run) m_mode = c_RUN;
                c_RUN:   if (!bus.run) m_mode = c_DRAIN;
                default: if (bus.run) m_mode = c_RUN;
                         else if (nb == 0 && !inf) m_mode = c_IDLE;
            endcase
`ifdef FIFO_STREAM_READER_CNT_EN
            if (bus.count_clear) m_count = 32'd0;
            else if (e_pop) m_count = m_count + 32'd1;
`endif
        end
        #1;
        if (e_re) bus.fifo_data = m_infl_word;
        if (toggle_empty) force_empty = !force_empty;
        drive_fifo();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_deliv(input int n, input int budget);
        for (int i = 0; i < budget && deliv.size() < n; i++) tick();
        check("deliv_count", deliv.size(), n);
    endtask

    task automatic load4();
        q_fifo = '{8'h33, 8'hCC, 8'h0F, 8'hF0};
        drive_fifo();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc = 0; force_empty = 0; toggle_empty = 0;
        clear_model();
        clear_obs();
        bus.run = 1'b1; bus.out_ready = 1'b0; bus.fifo_data = '0; bus.fifo_empty = 1'b0;
`ifdef FIFO_STREAM_READER_CNT_EN
        bus.count_clear = 1'b0;
`endif
        // Reset with run=1 and a non-empty FIFO flag
        ticks(3);
        check("rst_read_enable_lit", bus.read_enable, 0);
        check("rst_busy_lit", bus.busy, 0);
        bus.run = 1'b0;
        drive_fifo();
        reset = 1'b0;
        ticks(2);

        // Streaming
        load4();
        bus.out_ready = 1'b1;
        clear_obs();
        bus.run = 1'b1;
        wait_deliv(4, 20);
        check("stream_first_re_cycle", first_re, 1);
        check("stream_first_valid_cycle", first_valid, 3);
        check("stream_re_count", re_count, 4);
        check("stream_w0", deliv[0], 8'h33);
        check("stream_w1", deliv[1], 8'hCC);
        check("stream_w2", deliv[2], 8'h0F);
        check("stream_w3", deliv[3], 8'hF0);
        check("stream_busy_run", bus.busy, 1);
        bus.run = 1'b0;
        ticks(4);
        check("stream_idle_busy", bus.busy, 0);

        // Backpressure
        bus.out_ready = 1'b0;
        load4();
        clear_obs();
        bus.run = 1'b1;
        ticks(6);
        check("bp_re_count", re_count, 2);
        check("bp_hold_data", bus.out_data, 8'h33);
        check("bp_valid", bus.out_valid, 1);
        bus.out_ready = 1'b1;
        wait_deliv(4, 20);
        check("bp_w0", deliv[0], 8'h33);
        check("bp_w1", deliv[1], 8'hCC);
        check("bp_w2", deliv[2], 8'h0F);
        check("bp_w3", deliv[3], 8'hF0);
        bus.run = 1'b0;
        ticks(4);

        // Drain: run dropped in the cycle the second read fires
        load4();
        clear_obs();
        bus.run = 1'b1;
        ticks(2);
        bus.run = 1'b0;
        ticks(8);
        check("drain_deliv", deliv.size(), 2);
        check("drain_w0", deliv[0], 8'h33);
        check("drain_w1", deliv[1], 8'hCC);
        check("drain_re_count", re_count, 2);
        check("drain_fifo_left", q_fifo.size(), 2);
        check("drain_busy", bus.busy, 0);
        q_fifo.delete();
        drive_fifo();

        // Reset mid-operation, then no reads while run stays low
        load4();
        bus.out_ready = 1'b0;
        bus.run = 1'b1;
        ticks(4);
        reset = 1'b1;
        bus.run = 1'b0;
        ticks(2);
        reset = 1'b0;
        clear_obs();
        ticks(3);
        check("post_reset_re_count", re_count, 0);
        check("post_reset_valid", bus.out_valid, 0);
        q_fifo.delete();
        drive_fifo();

        // Empty toggling with random backpressure
        exp_seq.delete();
        for (int i = 0; i < 120; i++) begin
            q_fifo.push_back(8'((i * 37 + 11) & 8'hFF));
            exp_seq.push_back(8'((i * 37 + 11) & 8'hFF));
        end
        toggle_empty = 1'b1;
        force_empty = 1'b0;
        drive_fifo();
        clear_obs();
        bus.run = 1'b1;
        for (int i = 0; i < 200; i++) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            tick();
        end
        toggle_empty = 1'b0;
        force_empty = 1'b0;
        drive_fifo();
        bus.out_ready = 1'b1;
        bus.run = 1'b0;
        ticks(10);
        check("toggle_some_delivered", (deliv.size() > 10) ? 1 : 0, 1);
        for (int i = 0; i < deliv.size() && i < exp_seq.size(); i++)
            if (deliv[i] !== exp_seq[i]) check("toggle_order", deliv[i], exp_seq[i]);
        check("toggle_no_loss", deliv.size() + q_fifo.size(), 120);
        q_fifo.delete();
        drive_fifo();

`ifdef FIFO_STREAM_READER_CNT_EN
        reset = 1'b1;
        ticks(2);
        reset = 1'b0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 10; i++) q_fifo.push_back(8'(i + 1));
        drive_fifo();
        bus.run = 1'b1;
        for (int p = 0; p < 5; p++) begin
            for (int i = 0; i < 10 && m_buf.size() == 0; i++) tick();
            bus.out_ready = 1'b1;
            tick();
            bus.out_ready = 1'b0;
        end
        check("cnt_five", bus.word_count, 32'd5);
        for (int i = 0; i < 10 && m_buf.size() == 0; i++) tick();
        bus.out_ready = 1'b1;
        bus.count_clear = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        bus.count_clear = 1'b0;
        tick();
        check("cnt_clear_with_pop", bus.word_count, 32'd0);
        dut.r_word_count = 32'hFFFF_FFFF;
        m_count = 32'hFFFF_FFFF;
        for (int i = 0; i < 10 && m_buf.size() == 0; i++) tick();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        tick();
        check("cnt_wrap", bus.word_count, 32'd0);
        bus.run = 1'b0;
        ticks(4);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

`default_nettype wire
